// File: rtl/ghost_mode_scheduler.sv
// Ghost behaviour-mode sequencer: timed SCATTER/CHASE schedule, FRIGHTENED windows,
// DIED hold and PAUSE freezing, all driven by a shared one-second prescaler.
module ghost_mode_scheduler #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int SCATTER_S = 7,
    parameter int CHASE_S   = 20,
    parameter int ROUNDS    = 3,
    parameter int FRIGHT_S  = 6,
    parameter int WARN_S    = 2,
    parameter int DIED_S    = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_power_pellet,
    input  logic       i_pacman_caught,
    output logic [3:0] o_mode,
    output logic       o_mode_change,
    output logic       o_fright_warning,
    output logic [7:0] o_sec_left
);
    // Event inputs (start/pellet/caught) are one-cycle pulses sampled on each rising
    // edge; i_pause is a level. There is no back-pressure: every output is a register
    // that reflects the inputs sampled on the previous edge.

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CHASE   = 4'd1,
        S_SCATTER = 4'd2,
        S_FRIGHT  = 4'd3,
        S_DIED    = 4'd4,
        S_PAUSE   = 4'd5
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [7:0] SCATTER_T  = 8'(SCATTER_S);
    localparam logic [7:0] CHASE_T    = 8'(CHASE_S);
    localparam logic [7:0] FRIGHT_T   = 8'(FRIGHT_S);
    localparam logic [7:0] WARN_T     = 8'(WARN_S);
    localparam logic [7:0] DIED_T     = 8'(DIED_S);
    localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

    state_t          state, pause_ret, fright_ret;
    logic [PW-1:0]   presc;
    logic [7:0]      round, phase_sec, fright_sec, died_sec;

    state_t          nxt_state, nxt_pause_ret, nxt_fright_ret, view;
    logic [PW-1:0]   nxt_presc;
    logic [7:0]      nxt_round, nxt_phase, nxt_fright, nxt_died, nxt_sec;
    logic            nxt_change, counting, tick;

    always_comb begin
        nxt_state      = state;
        nxt_pause_ret  = pause_ret;
        nxt_fright_ret = fright_ret;
        nxt_round      = round;
        nxt_phase      = phase_sec;
        nxt_fright     = fright_sec;
        nxt_died       = died_sec;
        nxt_change     = 1'b0;

        // Permanent CHASE (phase_sec == 0) never ticks, so its prescaler stays parked.
        counting = (state == S_SCATTER) || (state == S_FRIGHT) || (state == S_DIED) ||
                   ((state == S_CHASE) && (phase_sec != 8'd0));
        tick     = counting && (presc == PRESC_MAX);
        nxt_presc = presc;
        if (counting) nxt_presc = tick ? '0 : presc + 1'b1;

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    nxt_round = 8'd0;
                    nxt_phase = SCATTER_T;
                    nxt_state = S_SCATTER;
                    nxt_presc = '0;
                end
            end
            S_PAUSE: begin
                if (!i_pause) nxt_state = pause_ret;
            end
            default: begin
                if (i_pause) begin
                    nxt_pause_ret = state;
                    nxt_state     = S_PAUSE;
                    nxt_presc     = presc;
                end else if ((state == S_SCATTER) || (state == S_CHASE)) begin
                    if (i_pacman_caught) begin
                        nxt_state = S_DIED;
                        nxt_died  = DIED_T;
                        nxt_presc = '0;
                    end else if (i_power_pellet) begin
                        nxt_fright_ret = state;
                        nxt_fright     = FRIGHT_T;
                        nxt_state      = S_FRIGHT;
                        nxt_presc      = '0;
                        nxt_change     = 1'b1;
                    end else if (tick) begin
                        if (phase_sec != 8'd1) begin
                            nxt_phase = phase_sec - 8'd1;
                        end else if (state == S_SCATTER) begin
                            nxt_state  = S_CHASE;
                            nxt_phase  = (round == LAST_ROUND) ? 8'd0 : CHASE_T;
                            nxt_change = 1'b1;
                        end else begin
                            nxt_round  = round + 8'd1;
                            nxt_state  = S_SCATTER;
                            nxt_phase  = SCATTER_T;
                            nxt_change = 1'b1;
                        end
                    end
                end else if (state == S_FRIGHT) begin
                    if (i_power_pellet) begin
                        nxt_fright = FRIGHT_T;
                        nxt_presc  = '0;
                    end else if (tick) begin
                        if (fright_sec == 8'd1) nxt_state = fright_ret;
                        else                    nxt_fright = fright_sec - 8'd1;
                    end
                end else if (tick) begin
                    if (died_sec == 8'd1) begin
                        nxt_state = S_IDLE;
                        nxt_round = 8'd0;
                    end else begin
                        nxt_died = died_sec - 8'd1;
                    end
                end
            end
        endcase

        // While paused, report the seconds of the state being resumed.
        view = (nxt_state == S_PAUSE) ? nxt_pause_ret : nxt_state;
        case (view)
            S_SCATTER, S_CHASE: nxt_sec = nxt_phase;
            S_FRIGHT:           nxt_sec = nxt_fright;
            S_DIED:             nxt_sec = nxt_died;
            default:            nxt_sec = 8'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= S_IDLE;
            pause_ret        <= S_IDLE;
            fright_ret       <= S_IDLE;
            presc            <= '0;
            round            <= 8'd0;
            phase_sec        <= 8'd0;
            fright_sec       <= 8'd0;
            died_sec         <= 8'd0;
            o_mode           <= 4'd0;
            o_mode_change    <= 1'b0;
            o_fright_warning <= 1'b0;
            o_sec_left       <= 8'd0;
        end else begin
            state            <= nxt_state;
            pause_ret        <= nxt_pause_ret;
            fright_ret       <= nxt_fright_ret;
            presc            <= nxt_presc;
            round            <= nxt_round;
            phase_sec        <= nxt_phase;
            fright_sec       <= nxt_fright;
            died_sec         <= nxt_died;
            o_mode           <= nxt_state;
            o_mode_change    <= nxt_change;
            o_fright_warning <= (nxt_state == S_FRIGHT) && (nxt_fright <= WARN_T);
            o_sec_left       <= nxt_sec;
        end
    end
endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Scoreboard bench for ghost_mode_scheduler: a cycle-count reference model pushes the
// expected outputs per stimulus cycle, a negedge monitor pops and compares them.
module tb_ghost_mode_scheduler;
    localparam int TD = 4, SC = 2, CH = 3, RN = 2, FR = 2, WN = 1, DD = 1;
    localparam int M_IDLE = 0, M_CHASE = 1, M_SCAT = 2, M_FRIGHT = 3, M_DIED = 4, M_PAUSE = 5;

    logic       clk = 1'b0;
    logic       rst, start, pause, pellet, caught;
    logic [3:0] mode;
    logic       mode_change, fright_warning;
    logic [7:0] sec_left;

    logic [13:0] exp_q[$];
    int checks = 0, passes = 0, fails = 0, chg_count = 0;

    // Reference model: remaining time of each timer kept in raw clock cycles.
    int m_mode = M_IDLE, m_phase = 0, m_fright = 0, m_died = 0, m_round = 0;
    int m_fret = 0, m_pret = 0;

    ghost_mode_scheduler #(
        .TICK_DIV(TD), .SCATTER_S(SC), .CHASE_S(CH), .ROUNDS(RN),
        .FRIGHT_S(FR), .WARN_S(WN), .DIED_S(DD)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause),
        .i_power_pellet(pellet), .i_pacman_caught(caught),
        .o_mode(mode), .o_mode_change(mode_change),
        .o_fright_warning(fright_warning), .o_sec_left(sec_left)
    );

    always #5 clk = ~clk;

    function automatic int ceil_s(input int cyc);
        return (cyc + TD - 1) / TD;
    endfunction

    task automatic model_step(input logic r, s, p, pl, c);
        int old, v, sec;
        bit chg, warn;
        old = m_mode;
        if (r) begin
            m_mode = M_IDLE; m_phase = 0; m_fright = 0; m_died = 0;
            m_round = 0; m_fret = 0; m_pret = 0;
        end else if (m_mode == M_IDLE) begin
            if (s) begin m_round = 0; m_phase = SC * TD; m_mode = M_SCAT; end
        end else if (m_mode == M_PAUSE) begin
            if (!p) m_mode = m_pret;
        end else if (p) begin
            m_pret = m_mode; m_mode = M_PAUSE;
        end else if ((m_mode == M_SCAT || m_mode == M_CHASE) && c) begin
            m_mode = M_DIED; m_died = DD * TD;
        end else if ((m_mode == M_SCAT || m_mode == M_CHASE) && pl) begin
            // Phase resumes with whole seconds left, since the tick restarts on return.
            m_fret = m_mode; m_fright = FR * TD; m_mode = M_FRIGHT;
            m_phase = ceil_s(m_phase) * TD;
        end else if (m_mode == M_FRIGHT && pl) begin
            m_fright = FR * TD;
        end else begin
            case (m_mode)
                M_SCAT: begin
                    m_phase--;
                    if (m_phase == 0) begin
                        m_mode = M_CHASE;
                        m_phase = (m_round == RN - 1) ? 0 : CH * TD;
                    end
                end
                M_CHASE: if (m_phase != 0) begin
                    m_phase--;
                    if (m_phase == 0) begin m_round++; m_mode = M_SCAT; m_phase = SC * TD; end
                end
                M_FRIGHT: begin
                    m_fright--;
                    if (m_fright == 0) m_mode = m_fret;
                end
                default: begin
                    m_died--;
                    if (m_died == 0) begin m_mode = M_IDLE; m_round = 0; end
                end
            endcase
        end
        chg = (m_mode == M_FRIGHT && (old == M_SCAT || old == M_CHASE)) ||
              (old == M_SCAT && m_mode == M_CHASE) || (old == M_CHASE && m_mode == M_SCAT);
        v = (m_mode == M_PAUSE) ? m_pret : m_mode;
        if (v == M_SCAT || v == M_CHASE) sec = ceil_s(m_phase);
        else if (v == M_FRIGHT)          sec = ceil_s(m_fright);
        else if (v == M_DIED)            sec = ceil_s(m_died);
        else                             sec = 0;
        warn = (m_mode == M_FRIGHT) && (sec <= WN);
        exp_q.push_back({4'(m_mode), chg, warn, 8'(sec)});
    endtask

    task automatic drive(input logic r, s, p, pl, c);
        rst = r; start = s; pause = p; pellet = pl; caught = c;
        model_step(r, s, p, pl, c);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [13:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({mode, mode_change, fright_warning, sec_left} === e) passes++;
            else begin
                fails++;
                $display("FAIL outputs @%0t: mode=%0d chg=%0b warn=%0b sec=%0d, expected mode=%0d chg=%0b warn=%0b sec=%0d",
                         $time, mode, mode_change, fright_warning, sec_left,
                         e[13:10], e[9], e[8], e[7:0]);
            end
            chg_count += int'(mode_change);
        end
    end

    initial begin
        logic p_lvl;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        chg_count = 0;

        // Full schedule: S8, C12, S8, then permanent CHASE.
        drive(0, 1, 0, 0, 0);
        idle(45);
        @(negedge clk); #1;
        check("schedule_change_pulses", chg_count, 3);

        // Pellet in timed CHASE, reload mid-fright, caught ignored in fright.
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        idle(12);
        drive(0, 0, 0, 1, 0);
        idle(5);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0);
        idle(14);
        drive(0, 0, 0, 0, 1);
        idle(6);

        // Restart after death, long pause mid-SCATTER, pause in IDLE.
        drive(0, 1, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 50; i++) drive(0, 0, 1, 0, 0);
        idle(12);
        drive(0, 0, 1, 1, 1);
        drive(0, 0, 1, 0, 0);
        idle(2);
        drive(0, 0, 0, 1, 0);
        idle(3);
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0);

        // Randomized traffic.
        p_lvl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) p_lvl = ~p_lvl;
            drive(logic'($urandom_range(0, 499) == 0), logic'($urandom_range(0, 9) == 0), p_lvl,
                  logic'($urandom_range(0, 24) == 0), logic'($urandom_range(0, 79) == 0));
        end
        drive(0, 0, 0, 0, 0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++; fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
